// File: rtl/score_argmax_reader.sv
// Snapshots accelerator class scores on a ready rise and streams out the signed argmax.
// Define SCORE_DUMP_EN to stream the whole snapshot ahead of the index beat.
module score_argmax_reader #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          acc_ready,
    input  logic [NUM_CLASSES*DATA_W-1:0] scores,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic [DATA_W-1:0]             max_score,
    output logic [IDX_W-1:0]              class_idx,
    output logic                          busy,
    output logic                          overrun
);

`ifdef SCORE_DUMP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DUMP = 2'd2,
        S_SEND = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_SEND = 2'd3
    } state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_acc_q;
    logic               w_rise;
    logic [DATA_W-1:0]  r_snap [NUM_CLASSES];
    logic [IDX_W-1:0]   r_ptr;
    logic [DATA_W-1:0]  r_max;
    logic [IDX_W-1:0]   r_idx;
    logic               r_overrun;
    logic               w_ptr_last;

    assign w_rise     = acc_ready & ~r_acc_q;
    assign w_ptr_last = (r_ptr == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_ptr_last) begin
`ifdef SCORE_DUMP_EN
                    w_next = S_DUMP;
`else
                    w_next = S_SEND;
`endif
                end
            end
`ifdef SCORE_DUMP_EN
            S_DUMP: begin
                out_valid = 1'b1;
                out_data  = r_snap[r_ptr];
                if (out_ready && w_ptr_last) begin
                    w_next = S_SEND;
                end
            end
`endif
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = {{(DATA_W-IDX_W){1'b0}}, r_idx};
                out_last  = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Rises outside IDLE are dropped but remembered in the sticky flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc_q   <= 1'b0;
            r_ptr     <= '0;
            r_max     <= '0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_snap[k] <= '0;
            end
        end else begin
            r_acc_q <= acc_ready;
            if (w_rise && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            r_snap[k] <= scores[k*DATA_W +: DATA_W];
                        end
                        r_max <= scores[DATA_W-1:0];
                        r_idx <= '0;
                        r_ptr <= IDX_W'(1);
                    end
                end
                S_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if ($signed(r_snap[r_ptr]) > $signed(r_max)) begin
                        r_max <= r_snap[r_ptr];
                        r_idx <= r_ptr;
                    end
                    r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;
                end
`ifdef SCORE_DUMP_EN
                S_DUMP: begin
                    if (out_ready && !w_ptr_last) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign max_score = r_max;
    assign class_idx = r_idx;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: doc/score_argmax_reader.md
Name: score_argmax_reader

Overview:
- Consumer end of the accelerator score interface.
- Watches the accelerator `ready` flag and snapshots the ten 32-bit class scores when it rises.
- Scans the snapshot sequentially for the signed maximum.
- Delivers the winning class index and score to the picoRV32-side logic over a valid/ready stream, so the CPU never samples live score wires.

Parameters:
- NUM_CLASSES, 10, number of score words; legal range 2..16.
- DATA_W, 32, width of each score word (signed two's complement).
- IDX_W, 4, width of the class index; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk  input  1  system clock, all state rising-edge.
- resetn  input  1  asynchronous active-low reset.
- acc_ready  input  1  accelerator done flag (`stop1 & stop2`), level signal.
- scores  input  NUM_CLASSES*DATA_W  flattened scores; class k at bits [k*DATA_W +: DATA_W].
- out_valid  output  1  result beat available.
- out_ready  input  1  downstream accepts beat.
- out_data  output  DATA_W  beat payload.
- out_last  output  1  final beat of a result.
- max_score  output  DATA_W  winning score, held until next capture.
- class_idx  output  IDX_W  winning class, held until next capture.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky: an acc_ready rising edge arrived while busy.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. resetn low clears:
  - state to IDLE and acc_ready_q to 0;
  - all outputs to 0;
  - the snapshot registers to 0.
- Reset mid-scan or mid-send: the result is dropped, no partial beat, and the next rising edge is required.
- Edge detect: rise = acc_ready & ~acc_ready_q, with acc_ready_q registered every cycle. A level held high never retriggers.
- IDLE:
  - on rise, capture all scores into the snapshot, max_score ← score0, class_idx ← 0, scan pointer ← 1, then go to SCAN;
  - on no rise, stay in IDLE.
- SCAN: one compare per cycle on snapshot[ptr].
  - If snapshot[ptr] > max_score (signed, strict), update max_score and class_idx.
  - Increment ptr; after ptr = NUM_CLASSES-1 is processed, go to SEND.
  - SCAN lasts NUM_CLASSES-1 cycles.
- Ties resolve to the lowest index.
- Latency: rise seen in cycle N means out_valid is high in cycle N+NUM_CLASSES (N+10 by default).
- SEND:
  - out_valid = 1, out_data = zero-extended class_idx, out_last = 1.
  - out_data, out_last and out_valid stay stable while out_ready = 0.
  - A beat transfers in a cycle with out_valid & out_ready; the next cycle is IDLE with out_valid = 0.
  - The earliest next capture is the cycle after the transfer.
- Rise while busy: ignored, overrun set to 1. overrun clears only on reset.
- Snapshot isolation: scores may change after capture without affecting the result.
- Simultaneous transfer and rise in the same SEND cycle: the rise is treated as busy, so it is ignored and overrun is set.
- Arithmetic: all comparisons are signed, DATA_W wide, with no saturation. Examples:
  - 0x80000000 is the minimum value;
  - 0x7FFFFFFF is the maximum value.

Optional Feature:
- Macro: SCORE_DUMP_EN.
- When defined:
  - a DUMP state is inserted after SCAN;
  - DUMP emits NUM_CLASSES beats, out_data = snapshot[0..NUM_CLASSES-1] in order, with out_last = 0;
  - DUMP then goes to SEND for the index beat with out_last = 1;
  - each beat follows the same valid/ready hold rules;
  - total beats per result = NUM_CLASSES+1.
- When undefined:
  - no DUMP state and no dump logic;
  - exactly one beat per result.
- max_score, class_idx, busy and overrun behave identically in both builds.

Test Plan:
- Scores = {5,9,3,9,-1,0,2,2,8,1}, acc_ready rises at cycle 0, out_ready = 1 → out_valid in cycle 10, out_data = 1, max_score = 9, class_idx = 1 (tie to lowest), out_last = 1.
- All scores negative, with score7 = 0xFFFFFFFF and the others ≤ 0x80000010 → class_idx = 7, max_score = 0xFFFFFFFF; confirms signed compare.
- out_ready held 0 for 20 cycles after out_valid, scores changed meanwhile → out_data stays stable and equal to the captured index; transfer on out_ready = 1; busy drops the next cycle.
- acc_ready held high 50 cycles → exactly one result; second pulse during SCAN → overrun = 1, still one result; a pulse after the transfer → new result.
- resetn asserted at cycle 4 of SCAN → all outputs 0 immediately (async); after release, no out_valid until a fresh acc_ready rise.
- With SCORE_DUMP_EN and scores 0..9 → 11 beats: 0,1,…,9 with out_last = 0, then 9 with out_last = 1; with random out_ready stalls the order is unchanged.
